alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencer that sits between the multi-cycle core's decode stage and the combinational ALU. It accepts one decoded operation per handshake, registers the operands, and translates the operation class into the ALU's 4-bit control code. It holds that code for the required number of cycles, captures the ALU result, and presents it to writeback on a valid/ready handshake. Multiply can be stretched over several cycles to relieve the ALU's critical path.

## Interface
- `TAG_W`, 5 — width of the destination-register tag carried with each operation.
- `MUL_LATENCY`, 3 — number of ALU-drive cycles for MUL when multicycle multiply is compiled in; legal range 1..15.
- `clk` input 1 — the only clock; all state updates on its rising edge.
- `reset` input 1 — synchronous, active-high.
- `in_valid` input 1 — decode presents an operation.
- `in_ready` output 1 — block can accept; high only in IDLE.
- `in_op` input 3 — operation class: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 PASS_A, 6–7 illegal.
- `in_a`, `in_b` input 32 — operands.
- `in_tag` input TAG_W — destination tag.
- `alu_ctrl` output 4 — to ALU: ADD 0001, SUB 0010, AND 0011, OR 0100, MUL 0101, PASS_A 1111; idle/illegal 0000.
- `alu_a`, `alu_b` output 32 — registered operands to ALU.
- `alu_result` input 32 — combinational ALU output.
- `out_valid` output 1 — result available.
- `out_ready` input 1 — writeback accepts.
- `out_result` output 32, `out_tag` output TAG_W, `out_illegal` output 1 — result, tag, illegal-op flag.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `in_a`/`in_b`/`in_tag`/`in_op` and go to EXEC. For illegal ops, set `out_illegal`, force result 0 and go directly to DONE.
- EXEC: `alu_ctrl` is driven from the latched op and `in_ready`=0.
  - Non-MUL ops: EXEC lasts 1 cycle. `alu_result` is captured into `out_result` at the end of that cycle, then the FSM goes to DONE.
  - MUL: a down-counter is loaded with MUL_LATENCY-1 on entry. The FSM stays in EXEC until the counter reaches 0, captures on that cycle, then goes to DONE.
  - `alu_a`, `alu_b` and `alu_ctrl` stay stable for the whole EXEC residency.
- DONE: `out_valid`=1 and `alu_ctrl`=0000. The FSM holds `out_result`, `out_tag` and `out_illegal` stable until `out_ready`, then returns to IDLE. There is no accept in the same cycle as DONE→IDLE: back-to-back throughput is one op per (latency+1) cycles.
- `alu_ctrl`=0000 in IDLE and DONE, so the ALU outputs 0 when idle.
- `in_valid` while busy is ignored; decode must hold it stable until `in_ready`.
- `out_illegal` clears on the next accept.

## Timing
- Reset values: FSM=IDLE, `in_ready`=1, `alu_ctrl`=0000, `alu_a`=`alu_b`=0, `out_valid`=0, `out_result`=0, `out_tag`=0, `out_illegal`=0, MUL counter=0.
- Accept at edge N for a non-MUL op:
  - EXEC occupies cycle N+1.
  - `out_valid` rises in cycle N+2.
- Accept at edge N for MUL with multicycle enabled:
  - EXEC occupies cycles N+1..N+MUL_LATENCY.
  - `out_valid` rises in cycle N+1+MUL_LATENCY.
- Accept at edge N for an illegal op: `out_valid` rises in cycle N+1.
- `out_ready` high on the first DONE cycle: DONE lasts exactly 1 cycle and `in_ready` is high the following cycle.
- Reset asserted in any state returns to IDLE with the reset values at the next edge. Any in-flight op is discarded with no `out_valid` pulse.
- Arithmetic: no width extension; the 32-bit result is whatever the ALU returns (MUL keeps the low 32 bits).

## Configuration
- `ALU_MUL_MULTICYCLE_EN`:
  - Defined: MUL stays in EXEC for MUL_LATENCY cycles as above.
  - Undefined: MUL is treated like every other op (1 EXEC cycle), the counter is not instantiated, and MUL_LATENCY is ignored.

## Test plan
- Reset, then ADD a=5, b=7, tag=3; `out_ready` tied high. Required: `alu_ctrl`=0001 in cycle N+1; `out_valid` in N+2 with result 12, tag 3; `in_ready` high again in N+3.
- SUB a=0, b=1 with `out_ready` held low for 4 cycles. Required: result 0xFFFFFFFF and `out_valid` both stay stable for all 4 cycles; `in_ready` stays low until the cycle after `out_ready`.
- With `ALU_MUL_MULTICYCLE_EN` and MUL_LATENCY=3, MUL a=6, b=7. Required: `alu_ctrl`=0101 for exactly cycles N+1..N+3; `out_valid` in N+4 with result 42. Without the macro: `out_valid` in N+2.
- `in_op`=6. Required: `out_valid` in N+1, `out_illegal`=1, result 0, and `alu_ctrl` never leaves 0000.
- Assert `reset` during the second EXEC cycle of a MUL. Required: next cycle is IDLE with all outputs at reset values; no `out_valid` pulse.
- PASS_A a=0xDEADBEEF, b=1, followed immediately by OR a=0xF0, b=0x0F. Required: results 0xDEADBEEF then 0xFF, in that order, with `in_valid` ignored while busy.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer between decode and the combinational ALU: latches one op per handshake,
// drives the ALU control code, captures the result and hands it to writeback.
// Optional: define ALU_MUL_MULTICYCLE_EN to hold MUL in EXEC for MUL_LATENCY cycles.
//
// state | meaning
// IDLE  | ready to accept an op from decode
// EXEC  | alu_ctrl/alu_a/alu_b driven from latched op; result captured on last cycle
// DONE  | out_valid high, result held until out_ready
module alu_issue_ctrl #(
  parameter int TAG_W       = 5,
  parameter int MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [3:0]       alu_ctrl,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;

  if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_mul_latency
    $error("alu_issue_ctrl: MUL_LATENCY must be within 1..15");
  end

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      result_q;
  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;
  logic             accept;
  logic             op_legal;
  logic             exec_last;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign op_legal = (in_op <= OP_PASS);

`ifdef ALU_MUL_MULTICYCLE_EN
  logic [3:0] mul_cnt;

  // Non-MUL ops always finish after one EXEC cycle; MUL waits for terminal count.
  assign exec_last = (op_q != OP_MUL) || (mul_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt <= 4'd0;
    end else if (accept && in_op == OP_MUL) begin
      mul_cnt <= 4'(MUL_LATENCY - 1);
    end else if (state == S_EXEC && mul_cnt != 4'd0) begin
      mul_cnt <= mul_cnt - 4'd1;
    end
  end
`else
  assign exec_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      tag_q     <= '0;
      result_q  <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= in_op;
            a_q   <= in_a;
            b_q   <= in_b;
            tag_q <= in_tag;
            if (op_legal) begin
              illegal_q <= 1'b0;
              state     <= S_EXEC;
            end else begin
              illegal_q <= 1'b1;
              result_q  <= 32'd0;
              state     <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          if (exec_last) begin
            result_q <= alu_result;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The ALU sees 0000 outside EXEC so it idles at zero.
  always_comb begin
    alu_ctrl = 4'b0000;
    if (state == S_EXEC) begin
      case (op_q)
        OP_ADD:  alu_ctrl = 4'b0001;
        OP_SUB:  alu_ctrl = 4'b0010;
        OP_AND:  alu_ctrl = 4'b0011;
        OP_OR:   alu_ctrl = 4'b0100;
        OP_MUL:  alu_ctrl = 4'b0101;
        OP_PASS: alu_ctrl = 4'b1111;
        default: alu_ctrl = 4'b0000;
      endcase
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign out_valid   = (state == S_DONE);
  assign out_result  = result_q;
  assign out_tag     = tag_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a behavioural ALU closes the loop, expected results
// are queued at issue time and a monitor checks them on each writeback handshake.
module tb_alu_issue_ctrl;

  localparam int TAG_W = 5;
  localparam int LAT   = 3;
`ifdef ALU_MUL_MULTICYCLE_EN
  localparam int MUL_EXEC = LAT;
  localparam int MC_EN    = 1;
`else
  localparam int MUL_EXEC = 1;
  localparam int MC_EN    = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'd0;
  logic [31:0]      in_a = 32'd0;
  logic [31:0]      in_b = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [3:0]       alu_ctrl;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_result;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  alu_issue_ctrl #(.TAG_W(TAG_W), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'd0;
    case (alu_ctrl)
      4'b0001: alu_result = alu_a + alu_b;
      4'b0010: alu_result = alu_a - alu_b;
      4'b0011: alu_result = alu_a & alu_b;
      4'b0100: alu_result = alu_a | alu_b;
      4'b0101: alu_result = alu_a * alu_b;
      4'b1111: alu_result = alu_a;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one pop per writeback handshake.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got result %h tag %h with nothing expected", out_result, out_tag);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
        chk("sb_illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an op once in_ready is seen, returns 1ns into the cycle after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] er, input logic ei,
                       input bit expect_out);
    int w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk("issue_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    if (expect_out) sbq.push_back('{res: er, tag: tag, ill: ei});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    chk({nm, "_alu_a"}, alu_a, 32'd0);
    chk({nm, "_alu_b"}, alu_b, 32'd0);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_out_result"}, out_result, 32'd0);
    chk({nm, "_out_tag"}, 32'(out_tag), 32'd0);
    chk({nm, "_out_illegal"}, 32'(out_illegal), 32'd0);
  endtask

  initial begin
    int n_ctrl, last_ctrl, valid_at, nz_ctrl, n_valid, w;

    tick();
    tick();
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD 5+7, ready high
    out_ready = 1'b1;
    issue(3'd0, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_ctrl_n1", 32'(alu_ctrl), 32'h1);
    chk("add_valid_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("add_valid_n2", 32'(out_valid), 32'd1);
    chk("add_ctrl_n2", 32'(alu_ctrl), 32'h0);
    @(negedge clk);
    chk("add_ready_n3", 32'(in_ready), 32'd1);

    // SUB 0-1 with writeback stalled for 4 cycles
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(3'd1, 32'd0, 32'd1, 5'd9, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sub_hold_valid", 32'(out_valid), 32'd1);
      chk("sub_hold_result", out_result, 32'hFFFF_FFFF);
      chk("sub_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("sub_rel_ready", 32'(in_ready), 32'd0);
    chk("sub_rel_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("sub_after_ready", 32'(in_ready), 32'd1);
    chk("sub_after_valid", 32'(out_valid), 32'd0);

    // MUL 6*7: count EXEC cycles and out_valid position relative to the accept edge
    issue(3'd4, 32'd6, 32'd7, 5'd4, 32'd42, 1'b0, 1'b1);
    n_ctrl = 0; last_ctrl = 0; valid_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (alu_ctrl == 4'b0101) begin
        n_ctrl++;
        last_ctrl = i;
      end
      if (out_valid === 1'b1 && valid_at == 0) valid_at = i;
    end
    chk("mul_ctrl_cycles", 32'(n_ctrl), 32'(MUL_EXEC));
    chk("mul_ctrl_last", 32'(last_ctrl), 32'(MUL_EXEC));
    chk("mul_valid_at", 32'(valid_at), 32'(MUL_EXEC + 1));

    // illegal op 6
    issue(3'd6, 32'h1234, 32'h5678, 5'd17, 32'd0, 1'b1, 1'b1);
    nz_ctrl = 0; valid_at = 0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 1) begin
        @(negedge clk);
        chk("ill_flag", 32'(out_illegal), 32'd1);
      end else begin
        @(negedge clk);
      end
      if (alu_ctrl != 4'b0000) nz_ctrl++;
      if (out_valid === 1'b1 && valid_at == 0) valid_at = i;
    end
    chk("ill_ctrl_nonzero", 32'(nz_ctrl), 32'd0);
    chk("ill_valid_at", 32'(valid_at), 32'd1);

    // reset during the second EXEC cycle of a MUL; writeback held off so any pulse is visible only here
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(3'd4, 32'd3, 32'd3, 5'd21, 32'd9, 1'b0, 1'b0);
    n_valid = 0;
    @(negedge clk);
    if (out_valid === 1'b1) n_valid++;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    if (out_valid === 1'b1) n_valid++;
    @(negedge clk);
    if (out_valid === 1'b1) n_valid++;
    chk("rst_mid_valid_pulses", 32'(n_valid), 32'(1 - MC_EN));
    chk_reset_vals("rst_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;

    // PASS_A then OR presented back to back with in_valid held high
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    in_valid = 1'b1;
    in_op = 3'd5; in_a = 32'hDEAD_BEEF; in_b = 32'd1; in_tag = 5'd1;
    sbq.push_back('{res: 32'hDEAD_BEEF, tag: 5'd1, ill: 1'b0});
    tick();
    in_op = 3'd3; in_a = 32'h0000_00F0; in_b = 32'h0000_000F; in_tag = 5'd2;
    sbq.push_back('{res: 32'h0000_00FF, tag: 5'd2, ill: 1'b0});
    @(negedge clk);
    chk("pass_alu_a_stable", alu_a, 32'hDEAD_BEEF);
    chk("pass_ctrl", 32'(alu_ctrl), 32'hF);
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("or_wait_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("or_alu_a", alu_a, 32'h0000_00F0);
    chk("or_ctrl", 32'(alu_ctrl), 32'h4);

    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
